// File: rtl/piso_nbit_tx.sv
// piso_nbit_tx: parallel-in/serial-out transmitter with valid/ready load, frame/done strobes and optional idle gap
module piso_nbit_tx #(
  parameter int N = 4,
  parameter int GAP = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic [N-1:0] d_par_in,
  input  logic         load_valid_in,
  output logic         load_ready_out,
  output logic         q_out,
  output logic         frame_out,
  output logic         done_out,
  output logic         busy_out
);
  localparam int BW = $clog2(N);
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [3:0]    gapcnt_q, gapcnt_d;
  logic          last, accept;
  // output decodes of registered state; an asserted reset forces every output low
  always_comb begin
    last = state_q == ST_SHIFT && bitcnt_q == BW'(N - 1);
    frame_out = !reset_ah_in && state_q == ST_SHIFT;
    q_out = frame_out && (MSB_FIRST ? shreg_q[N-1] : shreg_q[0]);
    done_out = !reset_ah_in && last;
    busy_out = !reset_ah_in && state_q != ST_IDLE;
    load_ready_out = !reset_ah_in && (state_q == ST_IDLE || (GAP == 0 && last));
    accept = load_valid_in && load_ready_out;
  end
  // next state: accept wins (also covers back-to-back on the last bit), else shift or count down the gap
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = d_par_in;
      bitcnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
      bitcnt_d = last ? '0 : bitcnt_q + BW'(1);
      state_d = last ? (GAP > 0 ? ST_GAP : ST_IDLE) : ST_SHIFT;
      gapcnt_d = last ? 4'(GAP) : gapcnt_q;
    end else if (state_q == ST_GAP) begin
      gapcnt_d = gapcnt_q - 4'd1;
      state_d = gapcnt_q == 4'd1 ? ST_IDLE : ST_GAP;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
    end
  end
endmodule

// File: tb/tb_piso_nbit_tx.sv
// tb_piso_nbit_tx: four configurations of piso_nbit_tx checked against a timestamp-based frame model
module tb_piso_nbit_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] vin = '0;
  logic [5:0] din [4];
  logic [3:0] qv, frv, dnv, bsv, rdv;
  int tests = 0;
  int fails = 0;
  int c = 0;
  int ns [4] = '{4, 4, 4, 6};
  int gs [4] = '{1, 1, 0, 2};
  int ms [4] = '{0, 1, 0, 1};
  int fs [4] = '{-1000, -1000, -1000, -1000};
  logic [5:0] fw [4];

  piso_nbit_tx #(.N(4), .GAP(1), .MSB_FIRST(1'b0)) u0 (.clk(clk), .reset_ah_in(rst), .d_par_in(din[0][3:0]),
    .load_valid_in(vin[0]), .load_ready_out(rdv[0]), .q_out(qv[0]), .frame_out(frv[0]), .done_out(dnv[0]), .busy_out(bsv[0]));
  piso_nbit_tx #(.N(4), .GAP(1), .MSB_FIRST(1'b1)) u1 (.clk(clk), .reset_ah_in(rst), .d_par_in(din[1][3:0]),
    .load_valid_in(vin[1]), .load_ready_out(rdv[1]), .q_out(qv[1]), .frame_out(frv[1]), .done_out(dnv[1]), .busy_out(bsv[1]));
  piso_nbit_tx #(.N(4), .GAP(0), .MSB_FIRST(1'b0)) u2 (.clk(clk), .reset_ah_in(rst), .d_par_in(din[2][3:0]),
    .load_valid_in(vin[2]), .load_ready_out(rdv[2]), .q_out(qv[2]), .frame_out(frv[2]), .done_out(dnv[2]), .busy_out(bsv[2]));
  piso_nbit_tx #(.N(6), .GAP(2), .MSB_FIRST(1'b1)) u3 (.clk(clk), .reset_ah_in(rst), .d_par_in(din[3]),
    .load_valid_in(vin[3]), .load_ready_out(rdv[3]), .q_out(qv[3]), .frame_out(frv[3]), .done_out(dnv[3]), .busy_out(bsv[3]));

  function automatic logic [4:0] obs(int i);
    return {qv[i], frv[i], dnv[i], bsv[i], rdv[i]};
  endfunction

  // expected {q, frame, done, busy, ready} for cycle c: frame spans fs..fs+N-1, gap spans the next GAP cycles
  function automatic logic [4:0] expv(int i);
    int j;
    logic f, dn, g, b, r;
    j = c - fs[i];
    f = j >= 0 && j < ns[i];
    dn = j == ns[i] - 1;
    g = j >= ns[i] && j < ns[i] + gs[i];
    b = f ? fw[i][ms[i] != 0 ? ns[i] - 1 - j : j] : 1'b0;
    r = !(f || g) || (gs[i] == 0 && dn);
    return rst ? 5'b0 : {b, f, dn, f || g, r};
  endfunction

  // model consumes this cycle's inputs, then the clock advances to the next cycle
  task automatic cycle();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      e = expv(i);
      if (rst) fs[i] = -1000;
      else if (vin[i] && e[0]) begin
        fs[i] = c + 1;
        fw[i] = din[i];
      end
    end
    @(posedge clk);
    #2;
    c++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vin = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs(i) !== expv(i)) begin fails++; $display("FAIL reset u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
      end
    end
    cycle();
    rst = 1'b0;
    #1;
    tests++;
    if (rdv !== 4'b1111 || frv !== 4'b0000 || bsv !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release got rdy=%b fr=%b busy=%b want rdy=1111 fr=0000 busy=0000", rdv, frv, bsv);
    end
  endtask

  task automatic test_lsb_msb();
    logic [3:0] s0, s1;
    s0 = '0;
    s1 = '0;
    cycle();
    vin = 4'b0011;
    din[0] = 6'hB;
    din[1] = 6'hB;
    #1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      vin = '0;
      #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs(i) !== expv(i)) begin fails++; $display("FAIL lsb_msb u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
      end
      s0[k] = qv[0];
      s1[k] = qv[1];
    end
    tests++;
    if (s0 !== 4'b1011) begin fails++; $display("FAIL lsb_seq got %b want 1011", s0); end
    tests++;
    if (s1 !== 4'b1101) begin fails++; $display("FAIL msb_seq got %b want 1101", s1); end
    cycle();
    #1;
    tests++;
    if (rdv[1:0] !== 2'b00 || frv[1:0] !== 2'b00) begin fails++; $display("FAIL gap1_cycle got rdy=%b fr=%b want 00 00", rdv[1:0], frv[1:0]); end
    cycle();
    #1;
    tests++;
    if (rdv[1:0] !== 2'b11) begin fails++; $display("FAIL gap1_after got rdy=%b want 11", rdv[1:0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    int frn, dnn;
    s = '0;
    frn = 0;
    dnn = 0;
    cycle();
    vin = 4'b0100;
    din[2] = 6'hA;
    #1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      din[2] = 6'h5;
      if (k == 4) vin = '0;
      #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs(i) !== expv(i)) begin fails++; $display("FAIL back_to_back u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
      end
      s[k] = qv[2];
      frn += int'(frv[2]);
      dnn += int'(dnv[2]);
    end
    tests++;
    if (s !== 8'h5A || frn != 8 || dnn != 2) begin
      fails++;
      $display("FAIL b2b_seq got bits=%h frames=%0d dones=%0d want bits=5a frames=8 dones=2", s, frn, dnn);
    end
    cycle();
    #1;
    tests++;
    if (frv[2] !== 1'b0 || rdv[2] !== 1'b1) begin fails++; $display("FAIL b2b_end got fr=%b rdy=%b want 0 1", frv[2], rdv[2]); end
  endtask

  task automatic test_gap2_hold_valid();
    int gapn;
    gapn = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      vin = 4'b1000;
      din[3] = 6'($urandom);
      #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs(i) !== expv(i)) begin fails++; $display("FAIL gap2_hold u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
      end
      if (bsv[3] && !frv[3]) gapn++;
    end
    tests++;
    if (gapn < 6 || gapn % 2 != 0) begin fails++; $display("FAIL gap2_count got %0d gap cycles want an even count of at least 6", gapn); end
    vin = '0;
  endtask

  task automatic test_reset_midframe();
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < 12; k++) cycle();
    vin = 4'b0001;
    din[0] = 6'hF;
    #1;
    cycle();
    vin = '0;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs(i) !== expv(i)) begin fails++; $display("FAIL midreset u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
    end
    tests++;
    if ({qv[0], frv[0], rdv[0]} !== 3'b000) begin fails++; $display("FAIL midreset_outs got q/fr/rdy=%b want 000", {qv[0], frv[0], rdv[0]}); end
    cycle();
    rst = 1'b0;
    vin = 4'b0001;
    din[0] = 6'h3;
    #1;
    tests++;
    if (rdv[0] !== 1'b1 || frv[0] !== 1'b0) begin fails++; $display("FAIL midreset_release got rdy=%b fr=%b want 1 0", rdv[0], frv[0]); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      vin = '0;
      #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs(i) !== expv(i)) begin fails++; $display("FAIL after_reset u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
      end
      s[k] = qv[0];
    end
    tests++;
    if (s !== 4'b0011) begin fails++; $display("FAIL after_reset_seq got %b want 0011", s); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle();
      rst = $urandom_range(0, 49) == 0;
      vin = 4'($urandom);
      for (int i = 0; i < 4; i++) din[i] = 6'($urandom);
      #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (obs(i) !== expv(i)) begin fails++; $display("FAIL random u%0d cyc %0d got %b want %b", i, c, obs(i), expv(i)); end
      end
    end
    rst = 1'b0;
    vin = '0;
  endtask

  initial begin
    test_reset();
    test_lsb_msb();
    test_back_to_back();
    test_gap2_hold_valid();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
